// File: rtl/show_ahead_prefetch_reader_pkg.sv
// Shared definitions for the show-ahead prefetch reader.
//
// Contents:
//   read_latency_ok    - legal-range test for READ_LATENCY, used by the top
//                        level to stop elaboration of an unsupported latency
//   usedw_width        - number of bits needed to hold an occupancy of
//                        0..depth (log2(depth) + 1)
//   inflight_popcount  - counts set bits of the in-flight valid shift register
//                        (zero-extended to MAX_READ_LATENCY bits)

package kanagawa_prefetch_pkg;

   localparam int MIN_READ_LATENCY = 1;
   localparam int MAX_READ_LATENCY = 4;
   localparam int INFLIGHT_W       = $clog2(MAX_READ_LATENCY + 1);

   function automatic bit read_latency_ok(input int rl);
      return (rl >= MIN_READ_LATENCY) && (rl <= MAX_READ_LATENCY);
   endfunction

   function automatic int usedw_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic [INFLIGHT_W-1:0] inflight_popcount(
      input logic [MAX_READ_LATENCY-1:0] bits
   );
      logic [INFLIGHT_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_READ_LATENCY; i++) begin
         n = n + INFLIGHT_W'(bits[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/show_ahead_prefetch_reader_fifo.sv
// Small register-based show-ahead FIFO used as the prefetch buffer.
//
// The head word is always presented on q while empty==0; rdreq pops it and
// the next word appears on the following cycle. A write lands in the tail and
// becomes visible one cycle later (no write-to-read bypass).
//
// Ports:
//   clock         single clock, posedge
//   rst           synchronous, active-high reset
//   wrreq, data   push a word (ignored while full)
//   full          occupancy == DEPTH
//   rdreq         pop the head word (ignored while empty)
//   empty         occupancy == 0
//   almost_empty  occupancy <= ALMOSTEMPTY_VAL
//   q             head word, valid while empty==0
//   usedw         occupancy, LOG_DEPTH+1 bits

module KanagawaShowAheadRegisterFifo #(
   parameter int DEPTH           = 2,
   parameter int WIDTH           = 32,
   parameter int ALMOSTEMPTY_VAL = 1,
   parameter int LOG_DEPTH       = $clog2(DEPTH)
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               wrreq,
   input  logic [WIDTH-1:0]   data,
   output logic               full,
   input  logic               rdreq,
   output logic               empty,
   output logic               almost_empty,
   output logic [WIDTH-1:0]   q,
   output logic [LOG_DEPTH:0] usedw
);

   localparam int PTR_W    = (LOG_DEPTH > 0) ? LOG_DEPTH : 1;
   localparam int USEDW_W  = LOG_DEPTH + 1;
   localparam int AE_CLAMP = (ALMOSTEMPTY_VAL > DEPTH) ? DEPTH : ALMOSTEMPTY_VAL;

   localparam logic [USEDW_W-1:0] AE_LEVEL   = USEDW_W'(AE_CLAMP);
   localparam logic [USEDW_W-1:0] FULL_LEVEL = USEDW_W'(DEPTH);
   localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [USEDW_W-1:0] count;
   logic               do_wr;
   logic               do_rd;

   // DEPTH need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty        = (count == '0);
   assign full         = (count == FULL_LEVEL);
   assign almost_empty = (count <= AE_LEVEL);
   assign usedw        = count;
   assign q            = mem[rd_ptr];

   assign do_rd = rdreq & ~empty;
   assign do_wr = wrreq & ~full;

   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
         if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
         case ({do_wr, do_rd})
            2'b10:   count <= count + USEDW_W'(1);
            2'b01:   count <= count - USEDW_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; stale entries are never visible because
   // count gates every read.
   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= data;
   end

endmodule

// File: rtl/show_ahead_prefetch_reader.sv
// Read-side adapter: turns a normal-mode upstream queue (q valid
// READ_LATENCY cycles after rdreq) into a show-ahead interface.
//
// Reads are issued speculatively whenever the words already buffered, plus
// those still in flight, plus the one landing this cycle, minus the one being
// popped this cycle, leave room in the prefetch buffer. That headroom test
// makes a buffer overflow impossible, and it still sustains one word per
// cycle when the consumer pops continuously.
//
// Ports:
//   clock         single clock, posedge
//   rst           synchronous, active-low reset
//   up_empty      upstream queue empty
//   up_rdreq      upstream read request (combinational, forced 0 in reset)
//   up_q          upstream data, valid READ_LATENCY cycles after up_rdreq
//   rdreq         downstream pop of the head word
//   empty         no word available on q
//   almost_empty  usedw <= ALMOSTEMPTY_VAL
//   q             head word, valid while empty==0
//   usedw         words held in the prefetch buffer (excludes in-flight)
//   underflow     sticky; set by rdreq while empty, cleared only by reset

module show_ahead_prefetch_reader
   import kanagawa_prefetch_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int READ_LATENCY    = 1,
   parameter int BUFFER_DEPTH    = READ_LATENCY + 1,
   parameter int LOG_DEPTH       = $clog2(BUFFER_DEPTH),
   parameter int ALMOSTEMPTY_VAL = 1
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               up_empty,
   output logic               up_rdreq,
   input  logic [WIDTH-1:0]   up_q,
   input  logic               rdreq,
   output logic               empty,
   output logic               almost_empty,
   output logic [WIDTH-1:0]   q,
   output logic [LOG_DEPTH:0] usedw,
   output logic               underflow
);

   if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
      $error("show_ahead_prefetch_reader: READ_LATENCY must be in 1..4");
   end
   if (BUFFER_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
      $error("show_ahead_prefetch_reader: BUFFER_DEPTH must be >= READ_LATENCY+1");
   end
   if (usedw_width(BUFFER_DEPTH) > LOG_DEPTH + 1) begin : g_bad_log_depth
      $error("show_ahead_prefetch_reader: LOG_DEPTH too small for BUFFER_DEPTH");
   end

   // Wide enough for BUFFER_DEPTH + MAX_READ_LATENCY without wrapping.
   localparam int SUM_W = LOG_DEPTH + INFLIGHT_W + 2;

   logic [READ_LATENCY-1:0] inflight_sr;
   logic [READ_LATENCY-1:0] inflight_sr_next;
   logic [INFLIGHT_W-1:0]   inflight;
   logic [SUM_W-1:0]        demand;
   logic                    arrive;
   logic                    pop;
   logic                    fifo_full;

   // Bit 0 takes this cycle's request; the MSB is the stage whose data is on
   // up_q right now.
   assign inflight_sr_next = READ_LATENCY'({inflight_sr, up_rdreq});
   assign arrive           = inflight_sr[READ_LATENCY-1];
   assign inflight         = inflight_popcount(MAX_READ_LATENCY'(inflight_sr))
                             - INFLIGHT_W'(arrive);

   assign pop = rdreq & ~empty;

   // pop implies usedw >= 1, so the subtraction cannot go negative.
   assign demand = SUM_W'(usedw) + SUM_W'(inflight) + SUM_W'(arrive) - SUM_W'(pop);

   assign up_rdreq = rst & ~up_empty & (demand < SUM_W'(BUFFER_DEPTH));

   always_ff @(posedge clock) begin
      if (!rst) begin
         inflight_sr <= '0;
         underflow   <= 1'b0;
      end else begin
         inflight_sr <= inflight_sr_next;
         if (rdreq & empty) underflow <= 1'b1;
      end
   end

   KanagawaShowAheadRegisterFifo #(
      .DEPTH           (BUFFER_DEPTH),
      .WIDTH           (WIDTH),
      .ALMOSTEMPTY_VAL (ALMOSTEMPTY_VAL),
      .LOG_DEPTH       (LOG_DEPTH)
   ) u_buffer (
      .clock        (clock),
      .rst          (~rst),
      .wrreq        (arrive),
      .data         (up_q),
      .full         (fifo_full),
      .rdreq        (pop),
      .empty        (empty),
      .almost_empty (almost_empty),
      .q            (q),
      .usedw        (usedw)
   );

   // The issue headroom rule means a word can never land on a full buffer.
   a_no_arrive_when_full : assert property (
      @(posedge clock) disable iff (!rst) !(arrive && fifo_full)
   );

endmodule

// File: tb/tb_show_ahead_prefetch_reader.sv
// Bench for show_ahead_prefetch_reader: four instances with READ_LATENCY 1..4,
// each fed by its own upstream queue model whose data appears READ_LATENCY
// cycles after the request is sampled.

module tb_show_ahead_prefetch_reader;

   localparam int N_INST = 4;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst;
   logic        up_empty_w [N_INST];
   logic        up_rdreq_w [N_INST];
   logic [31:0] up_q_w     [N_INST];
   logic        rdreq_w    [N_INST];
   logic        empty_w    [N_INST];
   logic        ae_w       [N_INST];
   logic [31:0] q_w        [N_INST];
   logic [3:0]  usedw_w    [N_INST];
   logic        uf_w       [N_INST];

   for (genvar g = 0; g < N_INST; g++) begin : g_dut
      localparam int RL = g + 1;
      localparam int UW = $clog2(RL + 1) + 1;
      logic [UW-1:0] uw;
      show_ahead_prefetch_reader #(.WIDTH(32), .READ_LATENCY(RL)) dut (
         .clock        (clock),
         .rst          (rst),
         .up_empty     (up_empty_w[g]),
         .up_rdreq     (up_rdreq_w[g]),
         .up_q         (up_q_w[g]),
         .rdreq        (rdreq_w[g]),
         .empty        (empty_w[g]),
         .almost_empty (ae_w[g]),
         .q            (q_w[g]),
         .usedw        (uw),
         .underflow    (uf_w[g])
      );
      assign usedw_w[g] = 4'(uw);
   end

   // upstream model state
   logic [31:0] upq   [N_INST][$];
   logic [31:0] dpipe [N_INST][4];

   // per-cycle snapshots taken on the falling edge
   logic        s_up    [N_INST];
   logic        s_empty [N_INST];
   logic        s_ae    [N_INST];
   logic [31:0] s_q     [N_INST];
   logic [3:0]  s_used  [N_INST];
   logic        s_uf    [N_INST];
   logic        uf_exp  [N_INST];

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   function automatic void refresh_up();
      for (int g = 0; g < N_INST; g++) up_empty_w[g] = (upq[g].size() == 0);
   endfunction

   // One clock cycle: snapshot outputs mid-cycle, then advance the upstream
   // model using the request sampled at the edge.
   task automatic cyc();
      @(negedge clock);
      for (int g = 0; g < N_INST; g++) begin
         s_up[g]    = up_rdreq_w[g];
         s_empty[g] = empty_w[g];
         s_ae[g]    = ae_w[g];
         s_q[g]     = q_w[g];
         s_used[g]  = usedw_w[g];
         s_uf[g]    = uf_w[g];
      end
      @(posedge clock);
      #1;
      for (int g = 0; g < N_INST; g++) begin
         for (int k = 3; k > 0; k--) dpipe[g][k] = dpipe[g][k-1];
         if (s_up[g] && upq[g].size() > 0) dpipe[g][0] = upq[g].pop_front();
         else dpipe[g][0] = 32'hDEAD_BEEF;
         up_q_w[g] = dpipe[g][g];
      end
      refresh_up();
   endtask

   // Load n random words into every upstream, start popping each instance as
   // soon as its empty falls, and check order, bubbles, usedw and latency.
   task automatic stream(int n);
      logic [31:0] expq [N_INST][$];
      int popped [N_INST];
      int issue_c [N_INST];
      int fall_c [N_INST];
      bit started [N_INST];
      logic [31:0] w;
      for (int g = 0; g < N_INST; g++) begin
         expq[g].delete();
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            upq[g].push_back(w);
            expq[g].push_back(w);
         end
         popped[g] = 0; issue_c[g] = -1; fall_c[g] = -1; started[g] = 0;
         rdreq_w[g] = 1'b0;
      end
      refresh_up();
      for (int c = 0; c < n + 10; c++) begin
         cyc();
         for (int g = 0; g < N_INST; g++) begin
            if (issue_c[g] < 0 && s_up[g]) issue_c[g] = c;
            if (fall_c[g] < 0 && !s_empty[g]) fall_c[g] = c;
            if (rdreq_w[g]) begin
               chk($sformatf("stream%0d_rl%0d_bubble_c%0d", n, g+1, c), s_empty[g], 1'b0);
               if (!s_empty[g]) begin
                  chk($sformatf("stream%0d_rl%0d_q%0d", n, g+1, popped[g]), s_q[g], expq[g][0]);
                  chk($sformatf("stream%0d_rl%0d_usedw%0d", n, g+1, popped[g]), s_used[g], 4'd1);
                  void'(expq[g].pop_front());
                  popped[g]++;
               end
            end
         end
         for (int g = 0; g < N_INST; g++) begin
            if (!empty_w[g]) started[g] = 1;
            rdreq_w[g] = started[g] && (popped[g] < n);
         end
      end
      for (int g = 0; g < N_INST; g++) begin
         chk($sformatf("stream%0d_rl%0d_popped", n, g+1), popped[g], n);
         chk($sformatf("stream%0d_rl%0d_latency", n, g+1), fall_c[g] - issue_c[g], g + 2);
         chk($sformatf("stream%0d_rl%0d_empty_after", n, g+1), s_empty[g], 1'b1);
         chk($sformatf("stream%0d_rl%0d_underflow", n, g+1), s_uf[g], uf_exp[g]);
         rdreq_w[g] = 1'b0;
      end
   endtask

   typedef struct {
      logic       rd;
      logic       exp_up;
      logic       exp_empty;
      logic       exp_ae;
      logic [3:0] exp_used;
      int         q_idx;
   } vec_t;

   vec_t        tbl [12];
   logic [31:0] fill_words [5];
   logic [31:0] mid_words [4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // fill/drain of the READ_LATENCY=1, depth-2 instance with 5 words upstream
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, -1};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, -1};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2,  0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd2,  0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1,  1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  2};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2,  2};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd2,  2};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd1,  3};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd1,  4};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, -1};
      for (int i = 0; i < 5; i++) fill_words[i] = 32'hA5A5_0000 + i;
      for (int i = 0; i < 4; i++) mid_words[i]  = 32'hC0DE_0000 + i;

      rst = 1'b0;
      for (int g = 0; g < N_INST; g++) begin
         rdreq_w[g] = 1'b0;
         up_q_w[g]  = '0;
         uf_exp[g]  = 1'b0;
         upq[g].delete();
         for (int k = 0; k < 4; k++) dpipe[g][k] = '0;
      end
      for (int i = 0; i < 5; i++) upq[0].push_back(fill_words[i]);
      refresh_up();

      // reset held for 3 cycles with upstream non-empty on instance 0
      for (int c = 0; c < 3; c++) begin
         cyc();
         chk($sformatf("reset_c%0d_up_rdreq", c), s_up[0], 1'b0);
      end
      for (int g = 0; g < N_INST; g++) begin
         chk($sformatf("reset_rl%0d_empty", g+1), s_empty[g], 1'b1);
         chk($sformatf("reset_rl%0d_almost_empty", g+1), s_ae[g], 1'b1);
         chk($sformatf("reset_rl%0d_usedw", g+1), s_used[g], 4'd0);
         chk($sformatf("reset_rl%0d_underflow", g+1), s_uf[g], 1'b0);
      end
      rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         rdreq_w[0] = tbl[i].rd;
         cyc();
         chk($sformatf("fill[%0d]_up_rdreq", i), s_up[0], tbl[i].exp_up);
         chk($sformatf("fill[%0d]_empty", i), s_empty[0], tbl[i].exp_empty);
         chk($sformatf("fill[%0d]_almost_empty", i), s_ae[0], tbl[i].exp_ae);
         chk($sformatf("fill[%0d]_usedw", i), s_used[0], tbl[i].exp_used);
         if (tbl[i].q_idx >= 0)
            chk($sformatf("fill[%0d]_q", i), s_q[0], fill_words[tbl[i].q_idx]);
      end
      rdreq_w[0] = 1'b0;

      // underflow: pop while empty
      rdreq_w[0] = 1'b1;
      cyc();
      chk("underflow_before", s_uf[0], 1'b0);
      chk("underflow_empty", s_empty[0], 1'b1);
      rdreq_w[0] = 1'b0;
      cyc();
      chk("underflow_set", s_uf[0], 1'b1);
      chk("underflow_usedw", s_used[0], 4'd0);
      chk("underflow_empty_after", s_empty[0], 1'b1);
      uf_exp[0] = 1'b1;

      stream(3);
      stream(1);
      stream(8);
      stream(16);

      // reset one cycle after two requests on the READ_LATENCY=3 instance
      for (int i = 0; i < 4; i++) upq[2].push_back(mid_words[i]);
      refresh_up();
      cyc();
      chk("mid_c0_up_rdreq", s_up[2], 1'b1);
      cyc();
      chk("mid_c1_up_rdreq", s_up[2], 1'b1);
      rst = 1'b0;
      cyc();
      chk("mid_in_reset_up_rdreq", s_up[2], 1'b0);
      rst = 1'b1;
      for (int g = 0; g < N_INST; g++) uf_exp[g] = 1'b0;
      cyc();
      chk("mid_release_up_rdreq", s_up[2], 1'b1);
      chk("mid_release_underflow_cleared", s_uf[0], 1'b0);
      chk("mid_release_empty", s_empty[2], 1'b1);
      chk("mid_release_usedw", s_used[2], 4'd0);
      for (int c = 0; c < 3; c++) begin
         cyc();
         chk($sformatf("mid_late_c%0d_empty", c), s_empty[2], 1'b1);
         chk($sformatf("mid_late_c%0d_usedw", c), s_used[2], 4'd0);
      end
      cyc();
      chk("mid_first_empty", s_empty[2], 1'b0);
      chk("mid_first_q", s_q[2], mid_words[2]);
      chk("mid_first_usedw", s_used[2], 4'd1);
      rdreq_w[2] = 1'b1;
      cyc();
      chk("mid_pop0_q", s_q[2], mid_words[2]);
      chk("mid_pop0_usedw", s_used[2], 4'd2);
      cyc();
      chk("mid_pop1_q", s_q[2], mid_words[3]);
      chk("mid_pop1_usedw", s_used[2], 4'd1);
      rdreq_w[2] = 1'b0;
      cyc();
      chk("mid_end_empty", s_empty[2], 1'b1);
      chk("mid_end_usedw", s_used[2], 4'd0);
      chk("mid_end_underflow", s_uf[2], 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
